// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse symbol sequencer.
// Symbol encoding, character limits, FIFO entry layout and assembler states.
package morse_pkg;

  localparam logic SYM_DOT  = 1'b0;
  localparam logic SYM_DASH = 1'b1;

  localparam int unsigned MAX_SYMBOLS = 5;
  localparam int unsigned CODE_W      = 5;
  localparam int unsigned LEN_W       = 3;

  localparam logic [LEN_W-1:0] LEN_SPACE = 3'd0;

  // One queued item: a character, or a word space when len == LEN_SPACE.
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [LEN_W-1:0]  len;
    logic              err;
  } fifo_entry_t;

  localparam fifo_entry_t SPACE_ENTRY = '{code: 5'd0, len: LEN_SPACE, err: 1'b0};

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_SPACE   = 1'b1
  } asm_state_t;

endpackage

// File: rtl/morse_out_fifo.sv
// Output queue for assembled characters and word spaces.
// First-word fall-through with a registered head; one write per cycle.
// Ports:
//   clk, reset     clock, async active-high reset
//   push/push_data write request and entry (discarded when full and not popping)
//   ready          consumer accepts head this cycle
//   out_valid/head registered head-of-queue outputs
//   drop           sticky, set when a write is discarded
module morse_out_fifo
  import morse_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  fifo_entry_t push_data,
  input  logic        ready,
  output logic        out_valid,
  output fifo_entry_t head,
  output logic        drop
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fifo_entry_t   mem [0:DEPTH-1];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_n;
  logic [AW:0]   fill, fill_n;
  logic          full, do_pop, do_push;
  fifo_entry_t   head_n;

  // Occupancy, accepted write/read and next head value.
  always_comb begin
    full    = (fill == (AW+1)'(DEPTH));
    do_pop  = out_valid & ready;
    do_push = push & (~full | do_pop);
    fill_n  = fill + (AW+1)'(do_push) - (AW+1)'(do_pop);
    rd_n    = do_pop ? rd_ptr + AW'(1) : rd_ptr;
    head_n  = mem[rd_n];
    // New head is the entry being written this cycle (bypass the array).
    if (do_push && (rd_n == wr_ptr)) head_n = push_data;
    if (fill_n == '0) head_n = '0;
  end

  // Entry storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers, fill level, registered head and sticky drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      head      <= '0;
      drop      <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr    <= rd_n;
      fill      <= fill_n;
      out_valid <= (fill_n != '0);
      head      <= head_n;
      drop      <= drop | (push & ~do_push);
    end
  end

endmodule

// File: rtl/morse_symbol_sequencer.sv
// Controller beside the Morse decoder FSM: unit-time base, symbol assembler
// and output queue with valid/ready hand-off.
// Optional build macro: MORSE_STATS_EN adds char_count (characters popped).
// Ports:
//   clk, reset              clock, async active-high reset
//   count_reset             synchronous clear of the unit timer
//   dot, dash, LG, WG       one-cycle pulses from the decoder FSM
//   count                   elapsed units since count_reset, saturating
//   out_valid/out_ready     queue head handshake
//   out_code/out_len/out_err head character (len 0 = word space)
//   drop                    sticky, an entry was lost on a full queue
//   char_count              (MORSE_STATS_EN) popped characters, wrapping
module morse_symbol_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned BITS        = 5,
  parameter int unsigned UNIT_CYCLES = 5000000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            count_reset,
  input  logic            dot,
  input  logic            dash,
  input  logic            LG,
  input  logic            WG,
  output logic [BITS-1:0] count,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      out_code,
  output logic [2:0]      out_len,
  output logic            out_err,
  output logic            drop
`ifdef MORSE_STATS_EN
  ,
  output logic [15:0]     char_count
`endif
);

  localparam int unsigned PW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PW-1:0] PRESCALE_MAX = PW'(UNIT_CYCLES - 1);

  logic [PW-1:0] prescaler;

  // Unit timer: count_reset wins over the prescaler wrap; count saturates.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      count     <= '0;
    end else if (count_reset) begin
      prescaler <= '0;
      count     <= '0;
    end else if (prescaler == PRESCALE_MAX) begin
      prescaler <= '0;
      if (count != '1) count <= count + BITS'(1);
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  asm_state_t        state_q, state_n;
  logic [CODE_W-1:0] code_q, code_n;
  logic [LEN_W-1:0]  len_q, len_n;
  logic              err_q, err_n;
  logic              push_c;
  fifo_entry_t       push_data_c;

  // Assembler state and partial character.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_COLLECT;
      code_q  <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      code_q  <= code_n;
      len_q   <= len_n;
      err_q   <= err_n;
    end
  end

  // Next state and queue writes; priority WG > LG > dash > dot.
  always_comb begin
    state_n     = state_q;
    code_n      = code_q;
    len_n       = len_q;
    err_n       = err_q;
    push_c      = 1'b0;
    push_data_c = '0;

    case (state_q)
      S_SPACE: begin
        // Trailing space after a word; the assembler is already empty.
        push_c      = 1'b1;
        push_data_c = SPACE_ENTRY;
        state_n     = S_COLLECT;
      end
      default: begin
        if (WG) begin
          push_c = 1'b1;
          if (len_q != LEN_SPACE) begin
            push_data_c = '{code: code_q, len: len_q, err: err_q};
            code_n      = '0;
            len_n       = '0;
            err_n       = 1'b0;
            state_n     = S_SPACE;
          end else begin
            push_data_c = SPACE_ENTRY;
          end
        end else if (LG && (len_q != LEN_SPACE)) begin
          push_c      = 1'b1;
          push_data_c = '{code: code_q, len: len_q, err: err_q};
          code_n      = '0;
          len_n       = '0;
          err_n       = 1'b0;
        end
      end
    endcase

    // Symbols are recorded in either state unless a gap pulse took priority.
    if (!WG && !LG && (dash || dot)) begin
      if (len_q < LEN_W'(MAX_SYMBOLS)) begin
        code_n = code_q | (CODE_W'(dash ? SYM_DASH : SYM_DOT) << len_q);
        len_n  = len_q + LEN_W'(1);
      end else begin
        err_n = 1'b1;
      end
    end
  end

  fifo_entry_t head;

  morse_out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (push_data_c),
    .ready     (out_ready),
    .out_valid (out_valid),
    .head      (head),
    .drop      (drop)
  );

  assign out_code = head.code;
  assign out_len  = head.len;
  assign out_err  = head.err;

`ifdef MORSE_STATS_EN
  // Characters taken by the consumer; spaces are not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      char_count <= '0;
    end else if (out_valid && out_ready && (head.len != LEN_SPACE)) begin
      char_count <= char_count + 16'd1;
    end
  end
`endif

endmodule
